// File: rtl/spi_host_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte master, MSB first, with optional chip-select
// hold across bytes for multi-byte transactions.
module spi_host_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              hold_ss_i,
    input  logic              release_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sck_o,
    output logic              ss_n_o,
    output logic              mosi_o,
    input  logic              miso_i,
    input  logic              miso_en_i
);

    localparam int unsigned CntW  = $clog2(CLK_DIV + 1);
    localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(CLK_DIV - 1);
    localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StTrail, StGap, StHold} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [EdgeW-1:0]    edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                hold_q, hold_d;
    logic                sck_q, sck_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                done_q, done_d;
    logic                cnt_last;
    logic                miso_bit;

    assign cnt_last = (cnt_q == CntLast);
    // A tri-stated slave reads as zero.
    assign miso_bit = miso_i & miso_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            hold_q    <= 1'b0;
            sck_q     <= 1'b0;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            hold_q    <= hold_d;
            sck_q     <= sck_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        hold_d    = hold_q;
        sck_d     = sck_q;
        ss_n_d    = ss_n_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle, StHold: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = StSetup;
                    tx_sh_d = tx_data_i;
                    hold_d  = hold_ss_i;
                    mosi_d  = tx_data_i[DATA_W-1];
                    ss_n_d  = 1'b0;
                    rx_sh_d = '0;
                    edge_d  = '0;
                end else if (state_q == StHold && release_i) begin
                    state_d = StGap;
                    ss_n_d  = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_last) begin
                    // First rising edge: sample bit MSB.
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_bit};
                    edge_d  = EdgeW'(1);
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_last) begin
                    cnt_d  = '0;
                    edge_d = edge_q + 1'b1;
                    if (edge_q == EdgeLast) begin
                        // Final falling edge: mosi keeps the last bit.
                        sck_d   = 1'b0;
                        state_d = StTrail;
                    end else if (sck_q) begin
                        sck_d   = 1'b0;
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end else begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_bit};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTrail: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    if (hold_q) begin
                        state_d = StHold;
                    end else begin
                        state_d = StGap;
                        ss_n_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o    = !(state_q == StIdle || state_q == StHold);
        done_o    = done_q;
        rx_data_o = rx_data_q;
        sck_o     = sck_q;
        ss_n_o    = ss_n_q;
        mosi_o    = mosi_q;
    end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SPI mode-0 master that drives the game's SPI slave pins (sck, ss, mosi) and reads its miso/miso_en pair back.
- Used in the system-level bench and in a future host/loader block to push level and config bytes into the game and read status back.
- Transfers are byte-oriented, MSB first.
- Chip-select can be held across bytes for multi-byte transactions.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period. Legal range 1..255. Minimum 4 when driving the game slave, for synchronizer margin.
- DATA_W, 8, bits per transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin transfer. Sampled only in IDLE or HOLD.
- tx_data  in  DATA_W  byte to send. Latched on accepted start.
- hold_ss  in  1  latched on accepted start. 1 keeps ss_n low after the byte.
- release  in  1  in HOLD, deassert ss_n without a transfer
- busy  out  1  high while a transfer or deselect gap is in progress
- done  out  1  one-cycle pulse when rx_data is valid
- rx_data  out  DATA_W  last received byte. Held until the next done.
- sck  out  1  SPI clock. CPOL=0.
- ss_n  out  1  slave select, active-low
- mosi  out  1  serial data out
- miso  in  1  serial data in
- miso_en  in  1  slave output enable. The sampled bit is miso AND miso_en, so a tri-stated slave reads as 0.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-transfer:
  - Outputs: sck=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=0.
  - Internals: state=IDLE, counters and shift registers cleared.
- States: IDLE, SETUP, SHIFT, TRAIL, GAP, HOLD.
- IDLE:
  - ss_n=1, busy=0.
  - start=1 → latch tx_data and hold_ss, go to SETUP.
  - Next cycle: ss_n=0, mosi=tx_data[DATA_W-1], busy=1.
- SETUP: wait CLK_DIV cycles, then SHIFT.
- SHIFT: sck toggles every CLK_DIV cycles for 2*DATA_W half-periods.
  - On each rising edge: shift (miso & miso_en) into the LSB of the rx shift register.
  - On each falling edge: present the next tx bit on mosi.
  - After the final falling edge, mosi holds the last bit. Go to TRAIL.
- TRAIL:
  - Wait CLK_DIV cycles.
  - On the last cycle: rx_data ← shift register, done=1 for one cycle.
  - Then, if latched hold_ss=1: go to HOLD; ss_n stays 0, busy=0 in the same cycle as done.
  - Otherwise: ss_n=1 and go to GAP, busy stays 1.
- GAP: ss_n=1 for CLK_DIV cycles, then IDLE with busy=0.
- HOLD:
  - ss_n=0, sck=0, busy=0.
  - start=1 → as in IDLE (SETUP timing identical, ss_n already low).
  - release=1 with start=0 → GAP.
  - start and release in the same cycle → start wins, release ignored.
- Timing with start accepted at cycle 0 (D=CLK_DIV, N=DATA_W):
  - ss_n low and mosi=MSB at cycle 1.
  - Rising edge k (k=1..N) at cycle 1+D*(2k-1).
  - Falling edge k at cycle 1+2Dk.
  - done at cycle 1+D*(2N+1).
  - Non-hold: busy low at 1+D*(2N+2).
- start while busy=1: ignored, no queueing.
- release outside HOLD: ignored.
- tx_data/hold_ss changes after acceptance: no effect on the current transfer.
- Divider counter width: clog2(CLK_DIV+1). No wrap beyond CLK_DIV-1.
- sck, ss_n and mosi are driven directly from registers, glitch-free.

Test Plan:
- Single byte, CLK_DIV=4, tx=0xA5, model slave returns 0x3C with miso_en=1:
  - mosi bits 1,0,1,0,0,1,0,1 stable at each sck rise.
  - rx_data=0x3C, done at cycle 69, ss_n high at 69, busy low at 73.
- miso_en=0 throughout, miso=1, tx=0xFF → rx_data=0x00, mosi all 1s.
- Two-byte hold: 0x12 with hold_ss=1, then 0x34 with hold_ss=0 issued the cycle after the first done:
  - ss_n low continuously from cycle 1 to the second done.
  - Exactly 16 sck rises.
  - Two done pulses.
- HOLD then release=1 and start=1 in the same cycle → transfer starts, ss_n stays low. Release alone later → ss_n high, busy high for 4 cycles.
- start pulsed at cycles 10 and 40 during a transfer → no effect. Exactly 8 sck rises. One done.
- rst asserted at cycle 30 mid-SHIFT → next cycle sck=0, ss_n=1, busy=0, rx_data=0. A new start after reset completes a normal transfer.
